divider_fsm: RTL and testbench
==============================

Name: divider_fsm

Overview:
- Multi-cycle unsigned integer divider for the datapath's divide operation.
- Uses a restoring shift-subtract algorithm and produces one quotient bit per clock.
- Runs free with no start input: it samples its operands, computes, pulses done, then immediately samples again.
- Downstream logic captures quotient/remainder on the done pulse.

Parameters:
- N, 16, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- dividend  input  N  unsigned dividend; sampled only in LOAD.
- divisor  input  N  unsigned divisor; sampled only in LOAD.
- quotient  output  N  registered unsigned quotient of the last completed operation.
- remainder  output  N  registered unsigned remainder of the last completed operation.
- done  output  1  registered; high for exactly one cycle when quotient/remainder update.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=LOAD; quotient=0, remainder=0, done=0.
  - All internal working registers cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced for it.
- States: LOAD, CALC, FINISH (2-bit enum).
- LOAD, 1 cycle:
  - Latch dividend into working register dq, divisor into dv.
  - Clear partial remainder pr (N+1 bits); set bit counter cnt=N.
  - done=0. Next state: CALC.
- CALC, N cycles, one per bit, MSB first:
  - Shift {pr,dq} left one bit; let t = shifted pr.
  - If t >= {1'b0,dv}: pr = t - dv and the new quotient LSB = 1.
  - Otherwise: pr = t and the new quotient LSB = 0.
  - cnt decrements each cycle; when cnt reaches 1, next state is FINISH.
- FINISH, 1 cycle:
  - quotient <= dq; remainder <= pr[N-1:0]; done <= 1.
  - Next state: LOAD.
- done is driven high on the edge that updates the outputs and returns low on the following edge.
- Latency: N+2 cycles from operand sampling to done; throughput is one result per N+2 cycles (18 for N=16).
- quotient/remainder hold their values between done pulses. Operand changes during CALC/FINISH have no effect on the current operation.
- Divide by zero (dv==0 latched):
  - quotient = all ones (2^N-1); remainder = latched dividend.
  - Uses the same N+2 latency; this falls out naturally from the algorithm and needs no special path.
- dividend < divisor: quotient=0, remainder=dividend.
- Invariant for nonzero divisor: dividend == quotient*divisor + remainder, with remainder < divisor.
- Arithmetic is unsigned only. The partial remainder is N+1 bits wide so the comparison cannot overflow for divisor >= 2^(N-1).

Decomposition:
- Package divider_pkg: state enum (LOAD, CALC, FINISH) and the counter width constant $clog2(N+1).
- Sub-module divider_step: purely combinational single iteration.
  - Inputs: pr, dq, dv.
  - Outputs: next pr, next dq.
  - Performs shift, compare, subtract and quotient-bit insertion.
- The FSM, counter and output registers live in divider_fsm.

Test Plan:
- Hold reset=0 for 2 cycles, then release -> quotient=0, remainder=0, done=0 during reset. First done occurs exactly 18 cycles after the first LOAD edge.
- dividend=2, divisor=12 -> quotient=0, remainder=2, done pulses for 1 cycle.
- dividend=100, divisor=7 -> quotient=14, remainder=2. dividend=65535, divisor=1 -> quotient=65535, remainder=0. dividend=65535, divisor=65535 -> quotient=1, remainder=0.
- dividend=1234, divisor=0 -> quotient=16'hFFFF, remainder=1234.
- Change dividend/divisor from 50/5 to 9/4 during CALC -> next done reports quotient=10, remainder=0. The following done reports quotient=2, remainder=1.
- Assert reset mid-CALC -> outputs clear on that edge, no done pulse. After release, a fresh 18-cycle operation completes with correct results. A random sweep of 1000 operand pairs must satisfy the invariant.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the restoring shift-subtract divider.
package divider_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int DEFAULT_N = 16;

    // The bit counter must hold the value N itself, hence N+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_N);

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {pr,dq} left, trial-subtract dv, insert quotient bit.
module divider_step #(
    parameter int N = 16
) (
    input  logic [N:0]   pr,
    input  logic [N-1:0] dq,
    input  logic [N-1:0] dv,
    output logic [N:0]   pr_next,
    output logic [N-1:0] dq_next
);

    logic [N+1:0] t;
    logic [N:0]   diff;
    logic         ge;

    // t keeps the bit shifted out of pr so the compare is exact even for dv >= 2^(N-1).
    assign t       = {pr, dq[N-1]};
    assign ge      = (t >= {2'b00, dv});
    assign diff    = t[N:0] - {1'b0, dv};
    assign pr_next = ge ? diff : t[N:0];
    assign dq_next = {dq[N-2:0], ge};

endmodule

// File: rtl/divider_fsm.sv
// Free-running multi-cycle unsigned divider: LOAD operands, N CALC steps, FINISH publishes result.
module divider_fsm
    import divider_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        next_state;
    logic [N:0]    pr;
    logic [N-1:0]  dq;
    logic [N-1:0]  dv;
    logic [CW-1:0] cnt;
    logic [N:0]    pr_next;
    logic [N-1:0]  dq_next;

    divider_step #(
        .N(N)
    ) u_step (
        .pr      (pr),
        .dq      (dq),
        .dv      (dv),
        .pr_next (pr_next),
        .dq_next (dq_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:    next_state = CALC;
            CALC:    next_state = (cnt == CW'(1)) ? FINISH : CALC;
            FINISH:  next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // NOTE: all state here updates with <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dq        <= '0;
            dv        <= '0;
            pr        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                LOAD: begin
                    dq  <= dividend;
                    dv  <= divisor;
                    pr  <= '0;
                    cnt <= CW'(N);
                end
                CALC: begin
                    pr  <= pr_next;
                    dq  <= dq_next;
                    cnt <= cnt - CW'(1);
                end
                FINISH: begin
                    quotient  <= dq;
                    remainder <= pr[N-1:0];
                    done      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_fsm.sv
// Directed and randomised self-checking bench for divider_fsm (N=16, 18-cycle period).
module tb_divider_fsm;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;

    int errors = 0;
    int checks = 0;

    divider_fsm #(
        .N(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Counts rising edges (sampled 1 time unit later) until done is seen; 0 means it never came.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Operands are applied just after a done pulse, so the next edge is the LOAD edge.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_q, input logic [N-1:0] exp_r);
        int cyc;
        dividend = a;
        divisor  = b;
        wait_done(cyc);
        check({tag, "_latency"}, cyc, 18);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
    endtask

    initial begin
        int cyc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        int sel;

        reset    = 1'b0;
        dividend = 16'd2;
        divisor  = 16'd12;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_q", quotient, 0);
            check("reset_r", remainder, 0);
            check("reset_done", done, 0);
        end
        reset = 1'b1;

        // First edge with reset high samples 2/12; done expected on the 18th edge.
        wait_done(cyc);
        check("first_latency", cyc, 18);
        check("small_q", quotient, 0);
        check("small_r", remainder, 2);

        run_op("div_100_7", 16'd100, 16'd7, 16'd14, 16'd2);
        run_op("div_max_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0);
        run_op("div_max_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0);
        run_op("div_by_zero", 16'd1234, 16'd0, 16'hFFFF, 16'd1234);
        run_op("div_big_dv", 16'd40000, 16'd32769, 16'd1, 16'd7231);

        // Operands change mid-CALC: current result must still be 50/5.
        dividend = 16'd50;
        divisor  = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        dividend = 16'd9;
        divisor  = 16'd4;
        wait_done(cyc);
        check("midchg_latency", cyc, 15);
        check("midchg_q", quotient, 10);
        check("midchg_r", remainder, 0);
        @(posedge clk);
        #1;
        check("pulse_width", done, 0);
        check("hold_q", quotient, 10);
        wait_done(cyc);
        check("next_latency", cyc, 17);
        check("next_q", quotient, 2);
        check("next_r", remainder, 1);

        // Reset in the middle of CALC aborts the operation and clears the outputs.
        dividend = 16'd100;
        divisor  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        #1;
        check("midrst_done2", done, 0);
        dividend = 16'd1000;
        divisor  = 16'd33;
        reset    = 1'b1;
        wait_done(cyc);
        check("postrst_latency", cyc, 18);
        check("postrst_q", quotient, 30);
        check("postrst_r", remainder, 10);

        for (int k = 0; k < 1000; k++) begin
            a   = N'($urandom_range(0, 65535));
            sel = $urandom_range(0, 3);
            if (sel == 0)      b = N'($urandom_range(0, 15));
            else if (sel == 1) b = N'($urandom_range(0, 255));
            else               b = N'($urandom_range(0, 65535));
            if (b == 0) begin
                eq = 16'hFFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op("sweep", a, b, eq, er);
            if (b != 0) begin
                check("sweep_invariant",
                      (32'(quotient) * 32'(b) + 32'(remainder) == 32'(a)) && (remainder < b), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
